// File: rtl/huffman_pkg.sv
// huffman_pkg: shared FSM state, clog2 helper and default
// parameters for the huffman_gen block.
package huffman_pkg;

  localparam int NSYM_D    = 6;
  localparam int SAMPLES_D = 100;
  localparam int CODE_W_D  = 8;
  localparam int CW_D      = 8;
  localparam int LEN_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    REPORT,
    MERGE,
    OUT
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/huffman_gen_if.sv
// huffman_gen_if: sample in, histogram and code/mask out.
// master drives samples and code_ready; slave is the generator.
// HUFFMAN_GEN_LEN_OUT_EN adds the per-symbol length bus L.
interface huffman_gen_if
  import huffman_pkg::*;
#(
  parameter int NSYM   = NSYM_D,
  parameter int CW     = CW_D,
  parameter int CODE_W = CODE_W_D
);
  logic                   gray_valid;
  logic [7:0]             gray_data;
  logic                   busy;
  logic                   CNT_valid;
  logic [NSYM*CW-1:0]     CNT;
  logic                   code_valid;
  logic                   code_ready;
  logic [NSYM*CODE_W-1:0] HC;
  logic [NSYM*CODE_W-1:0] M;
`ifdef HUFFMAN_GEN_LEN_OUT_EN
  logic [NSYM*LEN_W-1:0]  L;
`endif

  modport master (
    output gray_valid, gray_data, code_ready,
    input  busy, CNT_valid, CNT, code_valid, HC, M
`ifdef HUFFMAN_GEN_LEN_OUT_EN
    , input L
`endif
  );

  modport slave (
    input  gray_valid, gray_data, code_ready,
    output busy, CNT_valid, CNT, code_valid, HC, M
`ifdef HUFFMAN_GEN_LEN_OUT_EN
    , output L
`endif
  );

endinterface

// File: rtl/huffman_min2.sv
// huffman_min2: picks the two lightest active nodes.
// Ports: w_i/act_i/id_i node table in; a_o smallest, b_o next.
module huffman_min2
  import huffman_pkg::*;
#(
  parameter int NN = 11,
  parameter int WW = 8,
  parameter int IW = 4
) (
  input  logic [NN-1:0][WW-1:0] w_i,
  input  logic [NN-1:0]         act_i,
  input  logic [NN-1:0][IW-1:0] id_i,
  output logic [IW-1:0]         a_o,
  output logic [IW-1:0]         b_o
);

  logic          fa, fb;
  logic [WW-1:0] aw, bw;
  logic [IW-1:0] aid, bid, ai, bi;

  // Strict order on (weight, id): ties resolve to the lower id.
  function automatic logic lt(
    input logic [WW-1:0] wx,
    input logic [IW-1:0] ix,
    input logic [WW-1:0] wy,
    input logic [IW-1:0] iy
  );
    return (wx < wy) || ((wx == wy) && (ix < iy));
  endfunction

  always_comb begin
    fa  = 1'b0;
    aw  = '0;
    aid = '0;
    ai  = '0;
    for (int i = 0; i < NN; i++) begin
      if (act_i[i] &&
          (!fa || lt(w_i[i], id_i[i], aw, aid))) begin
        fa  = 1'b1;
        aw  = w_i[i];
        aid = id_i[i];
        ai  = IW'(i);
      end
    end
    fb  = 1'b0;
    bw  = '0;
    bid = '0;
    bi  = '0;
    for (int i = 0; i < NN; i++) begin
      if (act_i[i] && (IW'(i) != ai) &&
          (!fb || lt(w_i[i], id_i[i], bw, bid))) begin
        fb  = 1'b1;
        bw  = w_i[i];
        bid = id_i[i];
        bi  = IW'(i);
      end
    end
    a_o = ai;
    b_o = bi;
  end

endmodule

// File: rtl/huffman_gen.sv
// huffman_gen: histograms a frame of samples, then builds
// Huffman codes/masks one merge per cycle. Ports: clk, reset
// (async, active low), bus (huffman_gen_if.slave).
// Macro HUFFMAN_GEN_LEN_OUT_EN adds length output bus.L.
module huffman_gen
  import huffman_pkg::*;
#(
  parameter int NSYM    = NSYM_D,
  parameter int SAMPLES = SAMPLES_D,
  parameter int CODE_W  = CODE_W_D,
  parameter int CW      = CW_D
) (
  input logic          clk,
  input logic          reset,
  huffman_gen_if.slave bus
);

  localparam int NN = 2*NSYM - 1;
  localparam int IW = clog2(NN);
  localparam int WW = clog2(SAMPLES+1) + 1;
  localparam int SW = clog2(SAMPLES+1);

  state_t                      state_q, state_d;
  logic [SW-1:0]               scnt_q, scnt_d;
  logic [NSYM-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [NN-1:0][WW-1:0]       wgt_q, wgt_d;
  logic [NN-1:0]               act_q, act_d;
  logic [NN-1:0][IW-1:0]       ids;
  logic [NSYM-1:0][IW-1:0]     root_q, root_d;
  logic [NSYM-1:0][CODE_W-1:0] code_q, code_d;
  logic [NSYM-1:0][CODE_W-1:0] mask_q, mask_d;
  logic [NSYM-1:0][LEN_W-1:0]  len_q, len_d;
  logic [IW-1:0]               mcnt_q, mcnt_d;
  logic [IW-1:0]               ia, ib, nid;

  for (genvar i = 0; i < NN; i++) begin : g_id
    assign ids[i] = IW'(i);
  end

  huffman_min2 #(
    .NN(NN),
    .WW(WW),
    .IW(IW)
  ) u_min2 (
    .w_i  (wgt_q),
    .act_i(act_q),
    .id_i (ids),
    .a_o  (ia),
    .b_o  (ib)
  );

  assign nid = IW'(NSYM) + mcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      cnt_q   <= '0;
      wgt_q   <= '0;
      act_q   <= '0;
      root_q  <= '0;
      code_q  <= '0;
      mask_q  <= '0;
      len_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      cnt_q   <= cnt_d;
      wgt_q   <= wgt_d;
      act_q   <= act_d;
      root_q  <= root_d;
      code_q  <= code_d;
      mask_q  <= mask_d;
      len_q   <= len_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    cnt_d   = cnt_q;
    wgt_d   = wgt_q;
    act_d   = act_q;
    root_d  = root_q;
    code_d  = code_q;
    mask_d  = mask_q;
    len_d   = len_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      IDLE, COUNT: begin
        if (bus.gray_valid) begin
          scnt_d = scnt_q + 1'b1;
          // Out-of-range values still count toward the frame.
          for (int s = 0; s < NSYM; s++)
            if (bus.gray_data == 8'(s+1))
              cnt_d[s] = cnt_q[s] + 1'b1;
          if (scnt_q == SW'(SAMPLES-1))
            state_d = REPORT;
          else
            state_d = COUNT;
        end
      end
      REPORT: begin
        // Load leaves; zero-count leaves take part too.
        wgt_d  = '0;
        act_d  = '0;
        mcnt_d = '0;
        for (int s = 0; s < NSYM; s++) begin
          wgt_d[s]  = WW'(cnt_q[s]);
          act_d[s]  = 1'b1;
          root_d[s] = IW'(s);
        end
        state_d = MERGE;
      end
      MERGE: begin
        // Symbols under A get a 1 at bit len, under B a 0.
        for (int s = 0; s < NSYM; s++) begin
          if (root_q[s] == ia || root_q[s] == ib) begin
            if (root_q[s] == ia)
              code_d[s] = code_q[s]
                        | (CODE_W'(1) << len_q[s]);
            mask_d[s] = (mask_q[s] << 1) | CODE_W'(1);
            len_d[s]  = len_q[s] + 1'b1;
            root_d[s] = nid;
          end
        end
        act_d[ia]  = 1'b0;
        act_d[ib]  = 1'b0;
        act_d[nid] = 1'b1;
        wgt_d[nid] = wgt_q[ia] + wgt_q[ib];
        mcnt_d     = mcnt_q + 1'b1;
        if (mcnt_q == IW'(NSYM-2))
          state_d = OUT;
      end
      OUT: begin
        if (bus.code_ready) begin
          state_d = IDLE;
          scnt_d  = '0;
          cnt_d   = '0;
          wgt_d   = '0;
          act_d   = '0;
          root_d  = '0;
          code_d  = '0;
          mask_d  = '0;
          len_d   = '0;
          mcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == REPORT) ||
                    (state_q == MERGE)  ||
                    (state_q == OUT);
  assign bus.CNT_valid  = (state_q == REPORT);
  assign bus.code_valid = (state_q == OUT);

  // Symbol 1 lands in the most significant field.
  always_comb begin
    bus.CNT = '0;
    bus.HC  = '0;
    bus.M   = '0;
    for (int s = 0; s < NSYM; s++) begin
      bus.CNT[(NSYM-1-s)*CW +: CW] = cnt_q[s];
      if (state_q == OUT) begin
        bus.HC[(NSYM-1-s)*CODE_W +: CODE_W] = code_q[s];
        bus.M[(NSYM-1-s)*CODE_W +: CODE_W]  = mask_q[s];
      end
    end
  end

`ifdef HUFFMAN_GEN_LEN_OUT_EN
  always_comb begin
    bus.L = '0;
    for (int s = 0; s < NSYM; s++)
      if (state_q == OUT)
        bus.L[(NSYM-1-s)*LEN_W +: LEN_W] = len_q[s];
  end
`endif

endmodule

// File: doc/huffman_gen.md
HUFFMAN_GEN -- requirements
Module: huffman_gen

Interface
REQ-001 Parameter NSYM, default 6: number of symbols; legal range 2..8; symbol values are 1..NSYM.
REQ-002 Parameter SAMPLES, default 100: number of samples per frame.
REQ-003 Parameter CODE_W, default 8: per-symbol code/mask width; SHALL be at least NSYM-1.
REQ-004 Parameter CW, default 8: per-symbol count width; SHALL be able to hold SAMPLES.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port gray_valid, input, 1: sample strobe; gaps between strobes are allowed.
REQ-008 Port gray_data, input, 8: sample value.
REQ-009 Port busy, output, 1: high when samples are being ignored (states REPORT, MERGE, OUT).
REQ-010 Port CNT_valid, output, 1: one-cycle pulse that marks the final histogram.
REQ-011 Port CNT, output, NSYM*CW: histogram; symbol 1 occupies the MSB field.
REQ-012 Port code_valid, output, 1: codes available.
REQ-013 Port code_ready, input, 1: consumer accept.
REQ-014 Port HC, output, NSYM*CODE_W: codes, LSB-first from the leaf; symbol 1 occupies the MSB field.
REQ-015 Port M, output, NSYM*CODE_W: masks, equal to (1<<len)-1 per symbol.

Function
REQ-016 FSM states and transitions:
- IDLE->COUNT on the first gray_valid; that sample is counted.
- COUNT->REPORT when the SAMPLES-th sample is accepted.
- REPORT->MERGE after 1 cycle.
- MERGE->OUT after NSYM-1 cycles.
- OUT->IDLE on a cycle with code_valid&&code_ready.
REQ-017 Counting: each accepted sample advances the sample counter. A value v in 1..NSYM increments bin v. Any other value increments no bin but still counts toward SAMPLES.
REQ-018 CNT SHALL show the live bins at all times; CNT_valid SHALL be high exactly during REPORT.
REQ-019 Node table:
- Leaves are ids 0..NSYM-1 (symbol = id+1), all active, including zero-count leaves.
- Merged nodes take ids NSYM, NSYM+1, … in creation order.
- Node weight width is clog2(SAMPLES+1)+1.
REQ-020 Each MERGE cycle:
- Select the smallest active node A and the second-smallest B; ties go to the lower id.
- Every symbol under A gets a 1 at bit position len; every symbol under B gets a 0 at bit position len.
- Those symbols' len increments and a 1 is shifted into their mask.
- A and B are deactivated and a new node of weight A+B is activated.
REQ-021 code_valid SHALL be high throughout OUT. HC and M SHALL be zero outside OUT and held stable while code_ready is low.
REQ-022 gray_valid SHALL be ignored while busy is high; no bin changes.
REQ-023 Returning to IDLE clears bins, the sample counter, codes, masks and lengths.

Reset
REQ-024 Asserting reset SHALL at any time, including mid-COUNT or mid-MERGE, force IDLE and zero every bin, counter, node, code and mask.
REQ-025 Reset values of outputs: CNT=0, CNT_valid=0, code_valid=0, HC=0, M=0, busy=0.

Configuration
REQ-026 Macro HUFFMAN_GEN_LEN_OUT_EN, when defined, adds output port L, NSYM*4 bits, giving per-symbol code length with symbol 1 in the MSB field. L SHALL be valid with code_valid and be zero otherwise.
REQ-027 Without HUFFMAN_GEN_LEN_OUT_EN, port L and its logic SHALL be absent. All other behaviour SHALL be identical with and without the macro.

Structure
REQ-028 Package huffman_pkg SHALL hold:
- the state enum (IDLE, COUNT, REPORT, MERGE, OUT);
- a clog2 function;
- default parameter constants.
REQ-029 Sub-module huffman_min2 SHALL be combinational. Inputs: NSYM*2-1 weights, active flags and ids. Outputs: indices of A and B, using the lowest-id tie rule.

Verification (NSYM=6, SAMPLES=100, CODE_W=8)
REQ-030 Scenario 1:
- Stimulus: 40x1, 20x2, 15x3, 10x4, 10x5, 5x6, back-to-back, code_ready=1.
- Response: CNT=0x28140F0A0A05 with CNT_valid for exactly one cycle; code_valid 6 cycles later (5 MERGE cycles plus entry); HC=0x010002020303; M=0x0107070F070F.
REQ-031 Scenario 2: same samples as scenario 1 with random 0..3-cycle gaps, plus extra gray_valid pulses during MERGE -> identical CNT, HC and M.
REQ-032 Scenario 3:
- Stimulus: 90 samples of value 0 or 7, then 10x3.
- Response: CNT=0x00000A000000; frame ends after the 100th sample; the sum over symbols of 2^-len equals 1.
REQ-033 Scenario 4: scenario 1 with code_ready low for 10 cycles -> code_valid, HC and M held constant and busy=1; IDLE is re-entered the cycle after code_ready rises.
REQ-034 Scenario 5:
- Stimulus: assert reset during the 3rd MERGE cycle, release it, then replay scenario 1.
- Response: all outputs 0 during reset; the replay matches scenario 1 exactly.
REQ-035 Scenario 6: scenario 1 with HUFFMAN_GEN_LEN_OUT_EN defined -> L=0x133434 (4-bit fields: 1,3,3,4,3,4).
